// File: rtl/motor_mixer_seq.sv
// Time-multiplexed motor mixer: one shared multiplier walks the coefficient table, results stream out saturated.
// Optional airmode offset stage is enabled by defining MIXER_AIRMODE_EN.
module motor_mixer_seq #(
  parameter int MOTOR_COUNT = 4,
  parameter int DATA_W      = 32,
  parameter int FRAC_BITS   = 28,
  parameter int OUT_MIN     = 0,
  parameter int OUT_MAX     = 1 << 28,
  localparam int unsigned AW = $clog2(MOTOR_COUNT * 4),
  localparam int unsigned IW = (MOTOR_COUNT > 1) ? $clog2(MOTOR_COUNT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  input  logic              start,
  input  logic              armed,
  input  logic              failsafe,
  input  logic [DATA_W-1:0] in_throttle,
  input  logic [DATA_W-1:0] in_roll,
  input  logic [DATA_W-1:0] in_pitch,
  input  logic [DATA_W-1:0] in_yaw,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IW-1:0]     motor_index,
  output logic [DATA_W-1:0] motor_value,
  output logic              frame_done
);

  localparam int unsigned STEPS = 4 * MOTOR_COUNT;
  localparam int unsigned ACC_W = DATA_W + 2;
  localparam int unsigned SAT_W = ACC_W + 1;
  localparam int unsigned PW    = 2 * DATA_W;
  localparam logic signed [SAT_W-1:0] MIN_S = SAT_W'(OUT_MIN);
  localparam logic signed [SAT_W-1:0] MAX_S = SAT_W'(OUT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ADJUST, S_EMIT} state_t;

  state_t                   state;
  logic [AW-1:0]            cnt;
  logic signed [DATA_W-1:0] coef_tab [STEPS];
  logic signed [DATA_W-1:0] cmd_thr, cmd_roll, cmd_pitch, cmd_yaw;
  logic                     arm_l, fs_l;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  mbuf [MOTOR_COUNT];
  logic signed [ACC_W-1:0]  off_q;

  logic [1:0]               axis_c;
  logic [IW-1:0]            mot_c;
  logic [IW-1:0]            nidx_c;
  logic signed [DATA_W-1:0] cmd_c;
  logic signed [PW-1:0]     prod_c;
  logic signed [DATA_W-1:0] term_c;
  logic signed [ACC_W-1:0]  sum_c;
  logic                     en_c;

  assign axis_c = cnt[1:0];
  assign mot_c  = IW'(cnt >> 2);
  assign nidx_c = motor_index + IW'(1);
  assign en_c   = arm_l & ~fs_l;

  // Command select for the current axis, then one fixed-point MAC step
  always_comb begin
    cmd_c = cmd_thr;
    case (axis_c)
      2'd0: cmd_c = cmd_thr;
      2'd1: cmd_c = cmd_roll;
      2'd2: cmd_c = cmd_pitch;
      2'd3: cmd_c = cmd_yaw;
    endcase
  end

  assign prod_c = PW'(coef_tab[cnt]) * PW'(cmd_c);
  assign term_c = DATA_W'(prod_c >>> FRAC_BITS);
  assign sum_c  = ((axis_c == 2'd0) ? '0 : acc) + ACC_W'(term_c);

  // Offset subtraction is done one bit wider so it can never wrap before clamping
  function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] s,
                                            input logic signed [ACC_W-1:0] off,
                                            input logic en);
    logic signed [SAT_W-1:0] v;
    v = SAT_W'(s) - SAT_W'(off);
    if (!en)           sat = '0;
    else if (v < MIN_S) sat = DATA_W'(MIN_S);
    else if (v > MAX_S) sat = DATA_W'(MAX_S);
    else               sat = DATA_W'(v);
  endfunction

`ifdef MIXER_AIRMODE_EN
  localparam logic signed [ACC_W-1:0] MAX_A = ACC_W'(OUT_MAX);
  logic signed [ACC_W-1:0] max_acc;
  logic signed [ACC_W-1:0] off_c;
  assign off_c = (max_acc > MAX_A) ? (max_acc - MAX_A) : '0;
`else
  logic signed [ACC_W-1:0] first_c;
  // With one motor its sum lands in the buffer on the same edge that starts emission
  assign first_c = (MOTOR_COUNT == 1) ? sum_c : mbuf[0];
  assign off_q   = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      motor_index <= '0;
      motor_value <= '0;
      acc         <= '0;
      arm_l       <= 1'b0;
      fs_l        <= 1'b0;
      cmd_thr     <= '0;
      cmd_roll    <= '0;
      cmd_pitch   <= '0;
      cmd_yaw     <= '0;
      for (int i = 0; i < STEPS; i++) coef_tab[i] <= '0;
      for (int i = 0; i < MOTOR_COUNT; i++) mbuf[i] <= '0;
`ifdef MIXER_AIRMODE_EN
      max_acc     <= '0;
      off_q       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (coef_we && !busy) coef_tab[coef_addr] <= coef_data;

      case (state)
        S_IDLE: begin
          if (start) begin
            cmd_thr   <= in_throttle;
            cmd_roll  <= in_roll;
            cmd_pitch <= in_pitch;
            cmd_yaw   <= in_yaw;
            arm_l     <= armed;
            fs_l      <= failsafe;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= S_MAC;
          end
        end

        S_MAC: begin
          acc <= sum_c;
          cnt <= cnt + AW'(1);
          if (axis_c == 2'd3) begin
            mbuf[mot_c] <= sum_c;
`ifdef MIXER_AIRMODE_EN
            if (mot_c == '0 || sum_c > max_acc) max_acc <= sum_c;
`endif
          end
          if (cnt == AW'(STEPS - 1)) begin
`ifdef MIXER_AIRMODE_EN
            state <= S_ADJUST;
`else
            state       <= S_EMIT;
            out_valid   <= 1'b1;
            motor_index <= '0;
            motor_value <= sat(first_c, '0, en_c);
`endif
          end
        end

`ifdef MIXER_AIRMODE_EN
        S_ADJUST: begin
          off_q       <= off_c;
          state       <= S_EMIT;
          out_valid   <= 1'b1;
          motor_index <= '0;
          motor_value <= sat(mbuf[0], off_c, en_c);
        end
`endif

        S_EMIT: begin
          if (out_ready) begin
            if (motor_index == IW'(MOTOR_COUNT - 1)) begin
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              motor_index <= nidx_c;
              motor_value <= sat(mbuf[nidx_c], off_q, en_c);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_mixer_seq.sv
// Directed bench for motor_mixer_seq (4 motors, Q4.28); expectations adapt when MIXER_AIRMODE_EN is defined.
module tb_motor_mixer_seq;

  localparam int M = 4;
  localparam logic [31:0] ONE = 32'h1000_0000;
`ifdef MIXER_AIRMODE_EN
  localparam int AIR = 1;
`else
  localparam int AIR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [31:0] coef_data;
  logic        start, armed, failsafe;
  logic [31:0] in_throttle, in_roll, in_pitch, in_yaw;
  logic        busy, out_valid, out_ready, frame_done;
  logic [1:0]  motor_index;
  logic [31:0] motor_value;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_v [4];

  always #5 clk = ~clk;

  motor_mixer_seq dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .start(start), .armed(armed), .failsafe(failsafe),
    .in_throttle(in_throttle), .in_roll(in_roll), .in_pitch(in_pitch), .in_yaw(in_yaw),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .motor_index(motor_index), .motor_value(motor_value), .frame_done(frame_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Quad X: throttle 1.0 everywhere, roll +1.0 on motors 0/3 and -1.0 on motors 1/2
  task automatic load_quad();
    for (int m = 0; m < M; m++) begin
      for (int a = 0; a < 4; a++) begin
        coef_we   = 1'b1;
        coef_addr = 4'(m * 4 + a);
        coef_data = (a == 0) ? ONE : (a == 1) ? (((m == 0) || (m == 3)) ? ONE : -ONE) : 32'h0;
        tick();
      end
    end
    coef_we = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [31:0] thr, input logic [31:0] rol,
                       input logic arm, input logic fs, input int stall_beat, input int wr_cyc);
    int done_exp;
    in_throttle = thr;
    in_roll     = rol;
    in_pitch    = 32'h0;
    in_yaw      = 32'h0;
    armed       = arm;
    failsafe    = fs;
    start       = 1'b1;
    cyc         = 0;
    tick();
    start       = 1'b0;
    coef_we     = 1'b0;
    in_throttle = 32'hDEAD_BEEF;
    in_roll     = 32'h1234_5678;
    in_pitch    = 32'h7FFF_0000;
    in_yaw      = 32'h8000_1111;
    armed       = ~arm;
    failsafe    = ~fs;
    chk({tag, " busy_after_start"}, 64'(busy), 64'd1);
    while (!out_valid && cyc < 100) begin
      if (cyc == wr_cyc) begin
        coef_we   = 1'b1;
        coef_addr = 4'h0;
        coef_data = 32'h2000_0000;
      end else begin
        coef_we = 1'b0;
      end
      tick();
    end
    coef_we = 1'b0;
    chk({tag, " first_valid_cycle"}, 64'(cyc), 64'(17 + AIR));
    for (int b = 0; b < M; b++) begin
      chk($sformatf("%s idx%0d", tag, b), 64'(motor_index), 64'(b));
      chk($sformatf("%s val%0d", tag, b), 64'(motor_value), 64'(exp_v[b]));
      chk($sformatf("%s valid%0d", tag, b), 64'(out_valid), 64'd1);
      chk($sformatf("%s busy%0d", tag, b), 64'(busy), 64'd1);
      if (b == stall_beat) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk($sformatf("%s stall%0d idx", tag, s), 64'(motor_index), 64'(b));
          chk($sformatf("%s stall%0d val", tag, s), 64'(motor_value), 64'(exp_v[b]));
          chk($sformatf("%s stall%0d busy", tag, s), 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    done_exp = 5 * M + 1 + AIR + ((stall_beat >= 0) ? 5 : 0);
    chk({tag, " frame_done"}, 64'(frame_done), 64'd1);
    chk({tag, " done_cycle"}, 64'(cyc), 64'(done_exp));
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
    chk({tag, " valid_end"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, " done_pulse"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    start = 1'b0; armed = 1'b0; failsafe = 1'b0; out_ready = 1'b1;
    in_throttle = '0; in_roll = '0; in_pitch = '0; in_yaw = '0;
    repeat (3) tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset done", 64'(frame_done), 64'd0);
    chk("reset idx", 64'(motor_index), 64'd0);
    chk("reset val", 64'(motor_value), 64'd0);
    reset = 1'b0;
    tick();

    exp_v = '{32'h0, 32'h0, 32'h0, 32'h0};
    frame("zero_table", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, -1, -1);

    load_quad();
    exp_v = '{32'h0900_0000, 32'h0700_0000, 32'h0700_0000, 32'h0900_0000};
    frame("quad", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, -1, -1);

    exp_v = '{32'h0, 32'h0, 32'h0, 32'h0};
    frame("failsafe", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b1, -1, -1);
    frame("disarmed", 32'h0800_0000, 32'h0100_0000, 1'b0, 1'b0, -1, -1);

    if (AIR != 0) exp_v = '{32'h1000_0000, 32'h0C00_0000, 32'h0C00_0000, 32'h1000_0000};
    else          exp_v = '{32'h1000_0000, 32'h0E00_0000, 32'h0E00_0000, 32'h1000_0000};
    frame("sat", 32'h1000_0000, 32'h0200_0000, 1'b1, 1'b0, -1, -1);

    exp_v = '{32'h0900_0000, 32'h0700_0000, 32'h0700_0000, 32'h0900_0000};
    frame("stall", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, 2, -1);

    frame("mac_wr", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, -1, 3);
    frame("after_mac_wr", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, -1, -1);

    coef_we = 1'b1; coef_addr = 4'h0; coef_data = 32'h0800_0000;
    exp_v = '{32'h0500_0000, 32'h0700_0000, 32'h0700_0000, 32'h0900_0000};
    frame("idle_wr", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, -1, -1);

    load_quad();
    in_throttle = 32'h0800_0000; in_roll = 32'h0100_0000; armed = 1'b1; failsafe = 1'b0;
    start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    while (cyc < 6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset valid", 64'(out_valid), 64'd0);
    chk("midreset idx", 64'(motor_index), 64'd0);
    chk("midreset val", 64'(motor_value), 64'd0);
    tick();

    exp_v = '{32'h0, 32'h0, 32'h0, 32'h0};
    frame("post_reset_zero", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, -1, -1);
    load_quad();
    exp_v = '{32'h0900_0000, 32'h0700_0000, 32'h0700_0000, 32'h0900_0000};
    frame("post_reset", 32'h0800_0000, 32'h0100_0000, 1'b1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
